// File: rtl/mdu_iterative.sv
// mdu_iterative: RV32M/RV64M multiply/divide, shift-add multiplier and restoring divider.
// Build option MDU_SINGLE_CYCLE_MUL_EN: multiplies resolve combinationally at acceptance.
module mdu_iterative #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      op_sel_i,
    input  logic [XLEN-1:0] opr_a_i,
    input  logic [XLEN-1:0] opr_b_i,
    input  logic            kill_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [XLEN-1:0] res_o,
    output logic            busy_o
);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [XLEN-1:0]  ALL_ONES = '1;
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // hi half: running sum / partial remainder; lo half: multiplier / quotient
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN-1:0]   opb;
    logic [2:0]        op;
    logic              neg;
    logic [XLEN-1:0]   res;
    logic [CNT_W-1:0]  cnt;

    logic            accept;
    logic            finish;
    logic            in_div;
    logic            a_sgn;
    logic            b_sgn;
    logic            a_neg;
    logic            b_neg;
    logic            neg_new;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    logic            special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] final_res;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_tmp;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

`ifdef MDU_SINGLE_CYCLE_MUL_EN
    logic [2*XLEN-1:0] prod_fast;
`endif

    // Operand sign decode and magnitudes for the unsigned core
    always_comb begin
        in_div = op_sel_i[2];
        a_sgn = (op_sel_i == OP_MULH) || (op_sel_i == OP_MULHSU) ||
                (op_sel_i == OP_DIV) || (op_sel_i == OP_REM);
        b_sgn = (op_sel_i == OP_MULH) || (op_sel_i == OP_DIV) ||
                (op_sel_i == OP_REM);
        a_neg = a_sgn & opr_a_i[XLEN-1];
        b_neg = b_sgn & opr_b_i[XLEN-1];
        mag_a = a_neg ? -opr_a_i : opr_a_i;
        mag_b = b_neg ? -opr_b_i : opr_b_i;
        // remainder follows the dividend; everything else follows sign xor
        neg_new = (op_sel_i == OP_REM) ? a_neg : (a_neg ^ b_neg);
    end

    // Results known at acceptance that skip iteration
    always_comb begin
        special     = 1'b0;
        special_res = '0;
`ifdef MDU_SINGLE_CYCLE_MUL_EN
        prod_fast   = '0;
`endif
        if (in_div) begin
            if (opr_b_i == '0) begin
                special     = 1'b1;
                special_res = op_sel_i[1] ? opr_a_i : ALL_ONES;
            end else if (!op_sel_i[0] && opr_a_i == INT_MIN &&
                         opr_b_i == ALL_ONES) begin
                special     = 1'b1;
                special_res = op_sel_i[1] ? '0 : INT_MIN;
            end
        end else begin
`ifdef MDU_SINGLE_CYCLE_MUL_EN
            special   = 1'b1;
            prod_fast = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
            if (neg_new) begin
                prod_fast = -prod_fast;
            end
            special_res = (op_sel_i == OP_MUL) ? prod_fast[XLEN-1:0]
                                               : prod_fast[2*XLEN-1:XLEN];
`else
            if (opr_a_i == '0 || opr_b_i == '0) begin
                special = 1'b1;
            end
`endif
        end
    end

    // One multiply or divide step, plus sign fix-up of the stepped value
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
        div_tmp  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff = div_tmp - {1'b0, opb};
        div_ge   = !div_diff[XLEN];
        if (op[2]) begin
            acc_step = {(div_ge ? div_diff[XLEN-1:0] : div_tmp[XLEN-1:0]),
                        acc[XLEN-2:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc[XLEN-1:1]};
        end
        prod = neg ? -acc_step : acc_step;
        quo  = neg ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem  = neg ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        if (op[2]) begin
            final_res = op[1] ? rem : quo;
        end else begin
            final_res = (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshake strobes and outputs; kill wins over everything
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        finish      = 1'b0;
        req_ready_o = (state == IDLE);
        res_valid_o = (state == DONE);
        busy_o      = (state != IDLE);
        res_o       = res;
        if (kill_i) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        accept     = 1'b1;
                        state_next = special ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == CNT_LAST) begin
                        finish     = 1'b1;
                        state_next = DONE;
                    end
                end
                DONE: begin
                    if (res_ready_i) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Operand capture, iteration datapath, result and counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc <= '0;
            opb <= '0;
            op  <= '0;
            neg <= 1'b0;
            res <= '0;
            cnt <= '0;
        end else begin
            if (accept) begin
                op  <= op_sel_i;
                neg <= neg_new;
                acc <= {{XLEN{1'b0}}, (in_div ? mag_a : mag_b)};
                opb <= in_div ? mag_b : mag_a;
                if (special) begin
                    res <= special_res;
                end
            end else if (state == BUSY && !kill_i) begin
                acc <= acc_step;
                if (finish) begin
                    res <= final_res;
                end
            end
            cnt <= (state == BUSY && !kill_i) ? cnt + CNT_W'(1) : '0;
        end
    end

endmodule
